stage_ex_mem: RTL and testbench
===============================

// Module: stage_EX_MEM
// PURPOSE
//  Execute stage plus EX/MEM pipeline register. Sits directly downstream of the ID/EX register.
//  Resolves operand forwarding from its own EX/MEM output and from write-back.
//  Computes ALU results, with an iterative shift-add multiplier that stalls the front end.
//  Registers the result, store data and instruction for the MEM stage.
// PARAMETERS
//  DATA_WIDTH  20  datapath and instruction width
//  REG_BITS    4   register-index width (16 registers, no hardwired zero)
// PORTS
//  clock           in   1    single clock; all state updates on posedge
//  reset           in   1    synchronous, active-high
//  instruction     in   20   instruction from ID/EX
//  dataRFOut1      in   20   rs1 value from ID/EX
//  dataRFOut2      in   20   rs2 value from ID/EX
//  wb_we           in   1    write-back stage will write wb_dest
//  wb_dest         in   4    write-back destination register
//  wb_data         in   20   write-back data
//  alu_result      out  20   EX/MEM: ALU result, or memory address for LD/ST
//  store_data      out  20   EX/MEM: forwarded rs2 value, used by ST
//  instructionOut  out  20   EX/MEM: propagated instruction (0 = bubble)
//  opDestino       out  4    EX/MEM: instructionOut[15:12]
//  reg_write       out  1    EX/MEM: result targets the register file
//  stall           out  1    combinational; hold IF, ID and ID/EX while 1
// BEHAVIOUR
//  Fields: op=[19:16], rd=[15:12], rs1=[11:8], rs2=[7:4], imm12=[11:0].
//  Opcodes:
//   0 NOP | 1 ADD | 2 SUB | 3 AND | 4 OR | 5 SLT (signed, result 1/0) | 6 MUL (low 20 bits)
//   7 LDI: rd <= zero-extended imm12
//   8 LD: alu_result = opA
//   9 ST: alu_result = opA, store_data = opB
//   10-15: treated as NOP
//  reg_write=1 for ops 1-8 only.
//  Forwarding, for opA (rs1) and opB (rs2) independently:
//   - Priority 1: EX/MEM hit when reg_write=1, op!=LD and opDestino==rs -> alu_result.
//   - Priority 2: WB hit when wb_we=1 and wb_dest==rs -> wb_data.
//   - Otherwise: the dataRFOut value.
//   - A load-use hazard on an LD in EX/MEM is resolved upstream; this block does not detect it.
//  Arithmetic: ADD/SUB wrap modulo 2^20, no flags; SLT compares two's complement.
//  Single-cycle ops: result registered on the next posedge (latency 1), stall=0.
//  MUL FSM: states IDLE and BUSY.
//   - IDLE -> BUSY on a MUL with stall=0. Latch opA, opB and the instruction; accumulator=0; count=0.
//   - BUSY, each cycle: if multiplier LSB=1, add the multiplicand to the accumulator.
//     Then shift the multiplicand left and the multiplier right; count++.
//   - While BUSY, stall=1 and the EX/MEM outputs load a bubble (all zero).
//   - After the count reaches DATA_WIDTH-1, i.e. DATA_WIDTH cycles in BUSY, the FSM returns to IDLE.
//     On that same edge EX/MEM loads the product with reg_write=1.
//   - stall is asserted in the cycle the MUL enters EX and in every cycle in BUSY.
//     stall drops in the cycle the product appears.
//   - Total MUL occupancy: DATA_WIDTH+1 cycles.
//  Forwarding operands for a MUL are sampled on the IDLE->BUSY edge only.
//  Reset: all outputs 0, FSM to IDLE, accumulator and count cleared.
//   - Reset takes priority over any activity; reset mid-multiply aborts it and no product is emitted.
//  A bubble input (instruction=0) passes through as a bubble.
// STRUCTURE
//  Shared package: opcode constants, field bit positions, DATA_WIDTH and REG_BITS.
//  Sub-module: seq_multiplier (shift-add FSM with start/busy/done handshake and product output).
//  The ALU, forwarding muxes and EX/MEM register live in this module.
// TESTING
//  ADD r3,r1,r2 with dataRFOut1=5, dataRFOut2=7, no hazards
//   -> after 1 clk: alu_result=12, opDestino=3, reg_write=1.
//  ADD r4,r1,r1 then SUB r5,r4,r2 with r2=2
//   -> SUB uses the forwarded 12 (EX/MEM), alu_result=10.
//  Both EX/MEM and WB write r4 (EX/MEM=12, wb_data=99) -> EX/MEM value 12 wins.
//  MUL r6,r1,r2 with 0x00123 * 0x00010
//   -> stall high 21 cycles, bubbles emitted; then alu_result=0x01230, reg_write=1.
//  SLT with 0xFFFFF (-1) vs 1 -> result 1; ADD of 0xFFFFF and 1 -> result 0.
//  Reset asserted at BUSY cycle 7 -> next clk: all outputs 0, stall 0, no product ever emitted.

Source files
------------

// File: rtl/stage_ex_mem_pkg.sv
// Shared definitions for the execute stage and its EX/MEM register.
// Holds the datapath widths, the instruction field positions, the opcode
// constants and small field-extraction helpers used by the stage and the
// sequential multiplier.
package stage_ex_mem_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int REG_BITS   = 4;
    localparam int OP_BITS    = 4;
    localparam int IMM_BITS   = 12;

    // Instruction field positions (LSB of each field).
    localparam int OP_LSB  = 16;
    localparam int RD_LSB  = 12;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 4;

    localparam logic [OP_BITS-1:0] OP_NOP = 4'd0;
    localparam logic [OP_BITS-1:0] OP_ADD = 4'd1;
    localparam logic [OP_BITS-1:0] OP_SUB = 4'd2;
    localparam logic [OP_BITS-1:0] OP_AND = 4'd3;
    localparam logic [OP_BITS-1:0] OP_OR  = 4'd4;
    localparam logic [OP_BITS-1:0] OP_SLT = 4'd5;
    localparam logic [OP_BITS-1:0] OP_MUL = 4'd6;
    localparam logic [OP_BITS-1:0] OP_LDI = 4'd7;
    localparam logic [OP_BITS-1:0] OP_LD  = 4'd8;
    localparam logic [OP_BITS-1:0] OP_ST  = 4'd9;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

    function automatic logic [OP_BITS-1:0] field_op(input logic [DATA_WIDTH-1:0] instr);
        return instr[OP_LSB +: OP_BITS];
    endfunction

    function automatic logic [REG_BITS-1:0] field_rd(input logic [DATA_WIDTH-1:0] instr);
        return instr[RD_LSB +: REG_BITS];
    endfunction

    function automatic logic [REG_BITS-1:0] field_rs1(input logic [DATA_WIDTH-1:0] instr);
        return instr[RS1_LSB +: REG_BITS];
    endfunction

    function automatic logic [REG_BITS-1:0] field_rs2(input logic [DATA_WIDTH-1:0] instr);
        return instr[RS2_LSB +: REG_BITS];
    endfunction

endpackage

// File: rtl/stage_ex_mem_seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   start               accepted only in IDLE; latches both operands
//   multiplicand_in     first operand
//   multiplier_in       second operand
//   busy                high for exactly DATA_WIDTH cycles after start
//   done                high in the last busy cycle; product is valid then
//   product             low DATA_WIDTH bits of the product (valid with done)
module seq_multiplier
    import stage_ex_mem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] multiplicand_in,
    input  logic [DATA_WIDTH-1:0] multiplier_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    mul_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] acc_sum;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        // Accumulator after this cycle's partial product; also the final
        // product in the last busy cycle, so the stage can register it
        // on the same edge the FSM returns to IDLE.
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    state_d  = MUL_BUSY;
                    mcand_d  = multiplicand_in;
                    mplier_d = multiplier_in;
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            MUL_BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    state_d = MUL_IDLE;
                    count_d = '0;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = busy && (count_q == LAST_COUNT);
    assign product = acc_sum;

endmodule

// File: rtl/stage_ex_mem.sv
// stage_ex_mem: execute stage plus EX/MEM pipeline register.
// Resolves rs1/rs2 forwarding (EX/MEM first, then write-back, then the
// register-file values), evaluates the ALU and registers the result, the
// store data and the instruction for the MEM stage. MUL runs on the
// sequential multiplier and stalls the front end until the product is out.
// Ports:
//   clock, reset                     single clock, synchronous active-high reset
//   instruction                      instruction from ID/EX (0 = bubble)
//   dataRFOut1, dataRFOut2           rs1 / rs2 register-file values
//   wb_we, wb_dest, wb_data          write-back forwarding source
//   alu_result                       EX/MEM result (address for LD/ST)
//   store_data                       EX/MEM forwarded rs2 value
//   instructionOut, opDestino        EX/MEM instruction and its rd field
//   reg_write                        EX/MEM result targets the register file
//   stall                            combinational hold for IF, ID and ID/EX
module stage_ex_mem
    import stage_ex_mem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic [DATA_WIDTH-1:0] dataRFOut1,
    input  logic [DATA_WIDTH-1:0] dataRFOut2,
    input  logic                  wb_we,
    input  logic [REG_BITS-1:0]   wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] instructionOut,
    output logic [REG_BITS-1:0]   opDestino,
    output logic                  reg_write,
    output logic                  stall
);

    logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d;
    logic [DATA_WIDTH-1:0] store_data_q, store_data_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  reg_write_q, reg_write_d;
    // Set for the cycle in which the product is on EX/MEM; ID/EX still
    // holds the finished MUL then, and it must not start again.
    logic                  consumed_q, consumed_d;
    logic [DATA_WIDTH-1:0] mul_instr_q, mul_instr_d;
    logic [DATA_WIDTH-1:0] mul_opb_q, mul_opb_d;

    logic [OP_BITS-1:0]    op;
    logic [REG_BITS-1:0]   rs1, rs2;
    logic                  ex_fwd_ok;
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic [DATA_WIDTH-1:0] alu_val;
    logic                  mul_start, mul_busy, mul_done;
    logic [DATA_WIDTH-1:0] mul_product;

    assign op  = field_op(instruction);
    assign rs1 = field_rs1(instruction);
    assign rs2 = field_rs2(instruction);

    // A load's EX/MEM alu_result is an address, not the loaded data.
    assign ex_fwd_ok = reg_write_q && (field_op(instr_q) != OP_LD);

    always_comb begin
        op_a = dataRFOut1;
        if (ex_fwd_ok && (field_rd(instr_q) == rs1)) begin
            op_a = alu_result_q;
        end else if (wb_we && (wb_dest == rs1)) begin
            op_a = wb_data;
        end

        op_b = dataRFOut2;
        if (ex_fwd_ok && (field_rd(instr_q) == rs2)) begin
            op_b = alu_result_q;
        end else if (wb_we && (wb_dest == rs2)) begin
            op_b = wb_data;
        end
    end

    always_comb begin
        alu_val = '0;
        case (op)
            OP_ADD:        alu_val = op_a + op_b;
            OP_SUB:        alu_val = op_a - op_b;
            OP_AND:        alu_val = op_a & op_b;
            OP_OR:         alu_val = op_a | op_b;
            OP_SLT:        alu_val = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_LDI:        alu_val = {{(DATA_WIDTH-IMM_BITS){1'b0}}, instruction[IMM_BITS-1:0]};
            OP_LD, OP_ST:  alu_val = op_a;
            default:       alu_val = '0;
        endcase
    end

    assign mul_start = (op == OP_MUL) && !mul_busy && !consumed_q;
    assign stall     = mul_busy || mul_start;

    seq_multiplier u_mul (
        .clock           (clock),
        .reset           (reset),
        .start           (mul_start),
        .multiplicand_in (op_a),
        .multiplier_in   (op_b),
        .busy            (mul_busy),
        .done            (mul_done),
        .product         (mul_product)
    );

    always_comb begin
        // Default: EX/MEM loads a bubble.
        alu_result_d = '0;
        store_data_d = '0;
        instr_d      = '0;
        reg_write_d  = 1'b0;
        consumed_d   = 1'b0;
        mul_instr_d  = mul_instr_q;
        mul_opb_d    = mul_opb_q;

        if (mul_busy) begin
            if (mul_done) begin
                alu_result_d = mul_product;
                store_data_d = mul_opb_q;
                instr_d      = mul_instr_q;
                reg_write_d  = 1'b1;
                consumed_d   = 1'b1;
            end
        end else if (consumed_q) begin
            // Finished MUL still sitting in ID/EX: drop it.
        end else if (mul_start) begin
            mul_instr_d = instruction;
            mul_opb_d   = op_b;
        end else begin
            instr_d      = instruction;
            alu_result_d = alu_val;
            if ((op >= OP_ADD) && (op <= OP_ST)) begin
                store_data_d = op_b;
            end
            reg_write_d = (op >= OP_ADD) && (op <= OP_LD);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            instr_q      <= '0;
            reg_write_q  <= 1'b0;
            consumed_q   <= 1'b0;
            mul_instr_q  <= '0;
            mul_opb_q    <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            instr_q      <= instr_d;
            reg_write_q  <= reg_write_d;
            consumed_q   <= consumed_d;
            mul_instr_q  <= mul_instr_d;
            mul_opb_q    <= mul_opb_d;
        end
    end

    assign alu_result     = alu_result_q;
    assign store_data     = store_data_q;
    assign instructionOut = instr_q;
    assign opDestino      = field_rd(instr_q);
    assign reg_write      = reg_write_q;

endmodule

// File: tb/tb_stage_ex_mem.sv
// Bench for stage_ex_mem: directed cases followed by random instruction
// streams, every cycle checked against a behavioural model of the stage.
module tb_stage_ex_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] instruction;
    logic [19:0] dataRFOut1, dataRFOut2;
    logic        wb_we;
    logic [3:0]  wb_dest;
    logic [19:0] wb_data;
    logic [19:0] alu_result, store_data, instructionOut;
    logic [3:0]  opDestino;
    logic        reg_write, stall;

    int total = 0;
    int bad   = 0;

    // Model of the EX/MEM contents and of an outstanding multiply.
    logic [19:0] m_alu = '0, m_sd = '0, m_ins = '0;
    logic        m_rw = 1'b0;
    int          m_left = 0;
    bit          m_cons = 1'b0;
    logic [19:0] m_prod = '0, m_mins = '0, m_mopb = '0;

    always #5 clock = ~clock;

    stage_ex_mem dut (
        .clock          (clock),
        .reset          (reset),
        .instruction    (instruction),
        .dataRFOut1     (dataRFOut1),
        .dataRFOut2     (dataRFOut2),
        .wb_we          (wb_we),
        .wb_dest        (wb_dest),
        .wb_data        (wb_data),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .instructionOut (instructionOut),
        .opDestino      (opDestino),
        .reg_write      (reg_write),
        .stall          (stall)
    );

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [19:0] fwd(input logic [3:0] rs, input logic [19:0] rf);
        if (m_rw && m_ins[19:16] != 4'd8 && m_ins[15:12] == rs) return m_alu;
        if (wb_we && wb_dest == rs) return wb_data;
        return rf;
    endfunction

    function automatic int as_signed(input logic [19:0] v);
        return v[19] ? int'(v) - (1 << 20) : int'(v);
    endfunction

    function automatic logic [19:0] mk(input int op, input int rd, input int r1, input int r2);
        logic [19:0] w;
        w = {op[3:0], rd[3:0], r1[3:0], r2[3:0], 4'h0};
        return w;
    endfunction

    // One clock: check stall for the driven inputs, advance the model,
    // clock the DUT and compare the registered outputs.
    task automatic step(output bit stalled);
        logic [19:0] a, b, n_alu, n_sd, n_ins;
        logic        n_rw;
        bit          e_stall;
        int          op;
        #1;
        n_alu = '0; n_sd = '0; n_ins = '0; n_rw = 1'b0;
        op = int'(instruction[19:16]);
        a  = fwd(instruction[11:8], dataRFOut1);
        b  = fwd(instruction[7:4], dataRFOut2);
        if (m_left > 0)  e_stall = 1'b1;
        else if (m_cons) e_stall = 1'b0;
        else             e_stall = (op == 6);
        chk("stall", {19'b0, stall}, {19'b0, e_stall});
        stalled = e_stall;

        if (reset) begin
            m_left = 0;
            m_cons = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                n_alu = m_prod; n_sd = m_mopb; n_ins = m_mins; n_rw = 1'b1;
                m_cons = 1'b1;
            end
        end else if (m_cons) begin
            m_cons = 1'b0;
        end else if (op == 6) begin
            m_prod = 20'(longint'(a) * longint'(b));
            m_mins = instruction;
            m_mopb = b;
            m_left = 20;
        end else begin
            n_ins = instruction;
            case (op)
                1: n_alu = a + b;
                2: n_alu = a - b;
                3: n_alu = a & b;
                4: n_alu = a | b;
                5: n_alu = (as_signed(a) < as_signed(b)) ? 20'd1 : 20'd0;
                7: n_alu = {8'h00, instruction[11:0]};
                8, 9: n_alu = a;
                default: n_alu = '0;
            endcase
            if (op >= 1 && op <= 9) n_sd = b;
            n_rw = (op >= 1 && op <= 8);
        end
        m_alu = n_alu; m_sd = n_sd; m_ins = n_ins; m_rw = n_rw;

        @(posedge clock);
        #1;
        chk("instructionOut", instructionOut, m_ins);
        chk("opDestino", {16'b0, opDestino}, {16'b0, m_ins[15:12]});
        chk("reg_write", {19'b0, reg_write}, {19'b0, m_rw});
        // Data fields of NOP-class (0, 10-15) instructions are don't-care.
        if (m_ins == 20'd0 || (m_ins[19:16] >= 4'd1 && m_ins[19:16] <= 4'd9)) begin
            chk("alu_result", alu_result, m_alu);
            chk("store_data", store_data, m_sd);
        end
    endtask

    // Present one instruction from ID/EX, holding it while stall is high.
    task automatic issue(input logic [19:0] ins, input logic [19:0] d1, input logic [19:0] d2,
                         input bit rnd_wb);
        bit s;
        int guard;
        instruction = ins; dataRFOut1 = d1; dataRFOut2 = d2;
        guard = 0;
        do begin
            if (rnd_wb) begin
                wb_we   = 1'($urandom_range(0, 1));
                wb_dest = 4'($urandom_range(0, 15));
                wb_data = 20'($urandom);
            end
            step(s);
            guard++;
        end while (s && guard < 40);
        chk("stall_release", {19'b0, s}, 20'd0);
    endtask

    initial begin
        bit s;
        int stall_cnt;
        logic [19:0] d1, d2;

        reset = 1'b1; instruction = '0; dataRFOut1 = '0; dataRFOut2 = '0;
        wb_we = 1'b0; wb_dest = '0; wb_data = '0;
        @(posedge clock); #1;
        step(s);                                  // reset state check
        reset = 1'b0;

        // ADD r3,r1,r2: 5 + 7
        issue(mk(1, 3, 1, 2), 20'd5, 20'd7, 1'b0);
        chk("add_basic", alu_result, 20'd12);
        chk("add_rd", {16'b0, opDestino}, 20'd3);
        chk("add_rw", {19'b0, reg_write}, 20'd1);

        // ADD r4,r1,r1 then SUB r5,r4,r2 with WB also writing r4
        issue(mk(1, 4, 1, 1), 20'd6, 20'd6, 1'b0);
        wb_we = 1'b1; wb_dest = 4'd4; wb_data = 20'd99;
        issue(mk(2, 5, 4, 2), 20'd0, 20'd2, 1'b0);
        chk("sub_fwd_exmem", alu_result, 20'd10);

        // WB-only forwarding: ADD r7,r9,r0 with WB writing r9
        wb_we = 1'b1; wb_dest = 4'd9; wb_data = 20'd50;
        issue(mk(1, 7, 9, 0), 20'd1, 20'd4, 1'b0);
        chk("add_fwd_wb", alu_result, 20'd54);
        wb_we = 1'b0;

        // LD result must not be forwarded from EX/MEM
        issue(mk(8, 8, 1, 0), 20'h00040, 20'd0, 1'b0);
        issue(mk(1, 9, 8, 8), 20'd3, 20'd3, 1'b0);
        chk("no_fwd_from_ld", alu_result, 20'd6);

        // MUL r6,r1,r2: 0x123 * 0x10
        instruction = mk(6, 6, 1, 2); dataRFOut1 = 20'h00123; dataRFOut2 = 20'h00010;
        stall_cnt = 0;
        for (int i = 0; i < 21; i++) begin
            step(s);
            if (s) stall_cnt++;
        end
        chk("mul_stall_cycles", 20'(stall_cnt), 20'd21);
        chk("mul_product", alu_result, 20'h01230);
        chk("mul_rw", {19'b0, reg_write}, 20'd1);
        step(s);                                  // product cycle, MUL still held

        // SLT -1 < 1, ADD wrap
        issue(mk(5, 10, 1, 2), 20'hFFFFF, 20'd1, 1'b0);
        chk("slt_signed", alu_result, 20'd1);
        issue(mk(1, 11, 1, 2), 20'hFFFFF, 20'd1, 1'b0);
        chk("add_wrap", alu_result, 20'd0);
        issue(mk(7, 12, 0, 0) | 20'h00ABC, 20'd0, 20'd0, 1'b0);
        chk("ldi_imm", alu_result, 20'h00ABC);
        issue(mk(9, 0, 3, 5), 20'h00100, 20'h00777, 1'b0);
        chk("st_data", store_data, 20'h00777);
        issue(20'd0, 20'hFFFFF, 20'hFFFFF, 1'b0);
        chk("bubble_pass", instructionOut, 20'd0);

        // Reset in BUSY cycle 7 aborts the multiply
        instruction = mk(6, 6, 1, 2); dataRFOut1 = 20'h00321; dataRFOut2 = 20'h00005;
        for (int i = 0; i < 7; i++) step(s);      // entry cycle + BUSY 1..6
        reset = 1'b1; instruction = '0;
        step(s);
        reset = 1'b0;
        chk("reset_alu", alu_result, 20'd0);
        chk("reset_rw", {19'b0, reg_write}, 20'd0);
        for (int i = 0; i < 25; i++) step(s);     // no product may appear
        chk("abort_no_product", alu_result, 20'd0);

        // Random instruction stream with random write-back traffic
        for (int n = 0; n < 300; n++) begin
            d1 = 20'($urandom);
            d2 = 20'($urandom);
            if ($urandom_range(0, 3) == 0) d1 = 20'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) d2 = 20'hFFFFF - 20'($urandom_range(0, 3));
            issue(mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15)) | 20'($urandom_range(0, 15)), d1, d2, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
